// File: rtl/code_entry_fsm.sv
// ---------------------------------------------------------------------------
// code_entry_fsm
//   Keypad-side front end of a 4-digit BCD combination lock. Digit strobes
//   are collected into four BCD registers. Once four digits are held, the
//   block drives them to an external combinational comparator for a single
//   CHECK cycle. It samples the comparator's equal result there and then
//   sequences the unlock, error and lockout outputs.
//
// Ports
//   clk_i          in   1  system clock, rising edge
//   rst_i          in   1  asynchronous, active-high reset
//   key_valid_i    in   1  one-cycle strobe qualifying key_code_i
//   key_code_i     in   4  key value; 0-9 digits, 10-15 ignored
//   clear_i        in   1  discard partial entry (ENTRY only)
//   equal_i        in   1  comparator result, sampled while compare_en_o=1
//   bcd_0_o..3_o   out  4  digits in the order they were entered
//   compare_en_o   out  1  comparator enable, high only in CHECK
//   digit_count_o  out  3  digits stored so far, 0-4
//   unlock_o       out  1  correct code accepted (HOLD_CYCLES long)
//   error_o        out  1  wrong code entered (HOLD_CYCLES long)
//   lockout_o      out  1  MAX_FAILS consecutive failures (LOCKOUT_CYCLES long)
// ---------------------------------------------------------------------------
module code_entry_fsm #(
  parameter int unsigned HOLD_CYCLES    = 100,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 5000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       key_valid_i,
  input  logic [3:0] key_code_i,
  input  logic       clear_i,
  input  logic       equal_i,
  output logic [3:0] bcd_0_o,
  output logic [3:0] bcd_1_o,
  output logic [3:0] bcd_2_o,
  output logic [3:0] bcd_3_o,
  output logic       compare_en_o,
  output logic [2:0] digit_count_o,
  output logic       unlock_o,
  output logic       error_o,
  output logic       lockout_o
);

  // One timer is shared by the entry timeout and the three hold phases;
  // size it for the longest of them.
  localparam int unsigned T_MAX_A = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned T_MAX   = (T_MAX_A > LOCKOUT_CYCLES) ? T_MAX_A : LOCKOUT_CYCLES;
  localparam int unsigned TW      = $clog2(T_MAX + 1);
  localparam int unsigned FW      = $clog2(MAX_FAILS + 1);

  typedef enum logic [2:0] {
    S_ENTRY,
    S_CHECK,
    S_UNLOCKED,
    S_ERROR,
    S_LOCKOUT
  } state_e;

  state_e            state_q,   state_d;
  logic [3:0][3:0]   bcd_q,     bcd_d;
  logic [2:0]        count_q,   count_d;
  logic [TW-1:0]     timer_q,   timer_d;
  logic [FW-1:0]     fail_q,    fail_d;
  logic              unlock_q,  unlock_d;
  logic              error_q,   error_d;
  logic              lockout_q, lockout_d;

  logic key_ok;
  assign key_ok = key_valid_i && (key_code_i <= 4'd9);

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a
    // signal unassigned -- otherwise synthesis infers a latch.
    state_d   = state_q;
    bcd_d     = bcd_q;
    count_d   = count_q;
    timer_d   = timer_q;
    fail_d    = fail_q;
    unlock_d  = 1'b0;
    error_d   = 1'b0;
    lockout_d = 1'b0;

    unique case (state_q)
      S_ENTRY: begin
        if (clear_i) begin
          bcd_d   = '0;
          count_d = '0;
          timer_d = '0;
        end else if (key_ok) begin
          bcd_d[count_q[1:0]] = key_code_i;
          count_d = count_q + 3'd1;
          timer_d = '0;
          if (count_q == 3'd3) state_d = S_CHECK;
        end else if (count_q != 3'd0) begin
          // Timer holds idle cycles since the last accepted digit; the
          // TIMEOUT_CYCLES-th idle edge discards the partial entry.
          if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            bcd_d   = '0;
            count_d = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end

      S_CHECK: begin
        timer_d = '0;
        if (equal_i) begin
          fail_d  = '0;
          state_d = S_UNLOCKED;
        end else if (fail_q >= FW'(MAX_FAILS - 1)) begin
          fail_d  = FW'(MAX_FAILS);
          state_d = S_LOCKOUT;
        end else begin
          fail_d  = fail_q + FW'(1);
          state_d = S_ERROR;
        end
      end

      // Output flops follow the state by one edge, so the hold output rises
      // one cycle after entering the state and spans timer 0..HOLD-1.
      S_UNLOCKED, S_ERROR: begin
        if (timer_q == TW'(HOLD_CYCLES)) begin
          state_d = S_ENTRY;
          bcd_d   = '0;
          count_d = '0;
          timer_d = '0;
        end else begin
          unlock_d = (state_q == S_UNLOCKED);
          error_d  = (state_q == S_ERROR);
          timer_d  = timer_q + TW'(1);
        end
      end

      S_LOCKOUT: begin
        if (timer_q == TW'(LOCKOUT_CYCLES)) begin
          state_d = S_ENTRY;
          bcd_d   = '0;
          count_d = '0;
          timer_d = '0;
          fail_d  = '0;
        end else begin
          lockout_d = 1'b1;
          timer_d   = timer_q + TW'(1);
        end
      end

      default: begin
        state_d = S_ENTRY;
        bcd_d   = '0;
        count_d = '0;
        timer_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d from the same pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_ENTRY;
      bcd_q     <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      fail_q    <= '0;
      unlock_q  <= 1'b0;
      error_q   <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      fail_q    <= fail_d;
      unlock_q  <= unlock_d;
      error_q   <= error_d;
      lockout_q <= lockout_d;
    end
  end

  assign bcd_0_o       = bcd_q[0];
  assign bcd_1_o       = bcd_q[1];
  assign bcd_2_o       = bcd_q[2];
  assign bcd_3_o       = bcd_q[3];
  assign digit_count_o = count_q;
  assign compare_en_o  = (state_q == S_CHECK);
  assign unlock_o      = unlock_q;
  assign error_o       = error_q;
  assign lockout_o     = lockout_q;

endmodule

// File: tb/tb_code_entry_fsm.sv
// ---------------------------------------------------------------------------
// tb_code_entry_fsm
//   Directed bench for code_entry_fsm with default parameters. A behavioural
//   comparator (equal when the four digits match `target`) closes the loop.
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_code_entry_fsm;

  localparam int HOLD    = 100;
  localparam int TIMEOUT = 1000;
  localparam int LOCKOUT = 5000;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       key_valid_i;
  logic [3:0] key_code_i;
  logic       clear_i;
  logic       equal_i;
  logic [3:0] bcd_0_o, bcd_1_o, bcd_2_o, bcd_3_o;
  logic       compare_en_o;
  logic [2:0] digit_count_o;
  logic       unlock_o, error_o, lockout_o;

  logic [15:0] target = 16'h2801;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  assign equal_i = ({bcd_0_o, bcd_1_o, bcd_2_o, bcd_3_o} == target);

  code_entry_fsm dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .key_valid_i   (key_valid_i),
    .key_code_i    (key_code_i),
    .clear_i       (clear_i),
    .equal_i       (equal_i),
    .bcd_0_o       (bcd_0_o),
    .bcd_1_o       (bcd_1_o),
    .bcd_2_o       (bcd_2_o),
    .bcd_3_o       (bcd_3_o),
    .compare_en_o  (compare_en_o),
    .digit_count_o (digit_count_o),
    .unlock_o      (unlock_o),
    .error_o       (error_o),
    .lockout_o     (lockout_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {compare_en, unlock, error, lockout} as one 4-bit flag vector
  function automatic logic [3:0] flags();
    return {compare_en_o, unlock_o, error_o, lockout_o};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid_i = 1'b1;
    key_code_i  = k;
    step(1);
    key_valid_i = 1'b0;
  endtask

  // Enter four digits, check CHECK timing, return at edge N+2.
  task automatic run_code(input logic [15:0] code, input string tag);
    press(code[15:12]);
    press(code[11:8]);
    press(code[7:4]);
    press(code[3:0]);
    check({tag, " check"}, flags(), 4'b1000);
    step(1);
    check({tag, " gap"}, flags(), 4'b0000);
    step(1);
  endtask

  initial begin
    rst_i = 1'b1; key_valid_i = 1'b0; key_code_i = 4'd0; clear_i = 1'b0;
    step(3);
    check("reset flags", flags(), 4'b0000);
    check("reset count", digit_count_o, 3'd0);
    check("reset bcd", {bcd_0_o, bcd_1_o, bcd_2_o, bcd_3_o}, 16'h0000);
    rst_i = 1'b0;
    step(2);

    // 1: correct code
    run_code(16'h2801, "t1");
    check("t1 unlock rise", flags(), 4'b0100);
    check("t1 bcd", {bcd_0_o, bcd_1_o, bcd_2_o, bcd_3_o}, 16'h2801);
    step(HOLD - 1);
    check("t1 unlock last", flags(), 4'b0100);
    step(1);
    check("t1 unlock fall", flags(), 4'b0000);
    check("t1 count clr", digit_count_o, 3'd0);
    check("t1 bcd clr", {bcd_0_o, bcd_1_o, bcd_2_o, bcd_3_o}, 16'h0000);

    // 2: wrong codes, then lockout
    run_code(16'h2802, "t2a");
    check("t2 error rise", flags(), 4'b0010);
    step(HOLD - 1);
    check("t2 error last", flags(), 4'b0010);
    step(1);
    check("t2 error fall", flags(), 4'b0000);
    check("t2 count clr", digit_count_o, 3'd0);
    run_code(16'h2802, "t2b");
    check("t2 second error", flags(), 4'b0010);
    step(HOLD);
    run_code(16'h2802, "t2c");
    check("t2 lockout rise", flags(), 4'b0001);
    press(4'd5);
    check("t2 key in lockout", digit_count_o, 3'd4);
    check("t2 lockout held", flags(), 4'b0001);
    step(LOCKOUT - 2);
    check("t2 lockout last", flags(), 4'b0001);
    step(1);
    check("t2 lockout fall", flags(), 4'b0000);
    check("t2 count after lockout", digit_count_o, 3'd0);
    // fail counter cleared on lockout exit: one wrong code is only an error
    run_code(16'h1111, "t2d");
    check("t2 fails reset", flags(), 4'b0010);
    step(HOLD);

    // 3: clear
    press(4'd2);
    press(4'd8);
    clear_i = 1'b1; step(1); clear_i = 1'b0;
    check("t3 clear count", digit_count_o, 3'd0);
    check("t3 clear bcd0", bcd_0_o, 4'd0);
    run_code(16'h2801, "t3");
    check("t3 unlock", flags(), 4'b0100);
    step(HOLD);
    press(4'd2);
    clear_i = 1'b1; key_valid_i = 1'b1; key_code_i = 4'd8;
    step(1);
    clear_i = 1'b0; key_valid_i = 1'b0;
    check("t3 clear wins", digit_count_o, 3'd0);

    // 4: timeout
    press(4'd2);
    step(TIMEOUT - 1);
    check("t4 before timeout", digit_count_o, 3'd1);
    step(1);
    check("t4 timeout count", digit_count_o, 3'd0);
    check("t4 timeout flags", flags(), 4'b0000);
    press(4'd2);
    step(TIMEOUT - 1);
    press(4'd8);
    check("t4 key just in time", digit_count_o, 3'd2);
    clear_i = 1'b1; step(1); clear_i = 1'b0;

    // 5: invalid key ignored; correct code resets the fail streak
    press(4'd2);
    press(4'hB);
    check("t5 invalid ignored", digit_count_o, 3'd1);
    press(4'd8);
    press(4'd0);
    press(4'd1);
    check("t5 check", flags(), 4'b1000);
    step(2);
    check("t5 unlock", flags(), 4'b0100);
    step(HOLD);
    run_code(16'h9999, "t5a"); step(HOLD);
    run_code(16'h9999, "t5b"); step(HOLD);
    run_code(16'h2801, "t5c");
    check("t5 unlock between", flags(), 4'b0100);
    step(HOLD);
    run_code(16'h9999, "t5d"); step(HOLD);
    run_code(16'h9999, "t5e");
    check("t5 no lockout", flags(), 4'b0010);
    step(HOLD);

    // 6: asynchronous reset mid-unlock and mid-entry
    run_code(16'h2801, "t6");
    step(10);
    check("t6 unlocked", flags(), 4'b0100);
    #2 rst_i = 1'b1;
    #1;
    check("t6 async flags", flags(), 4'b0000);
    check("t6 async bcd", {bcd_0_o, bcd_1_o, bcd_2_o, bcd_3_o}, 16'h0000);
    step(1);
    rst_i = 1'b0;
    step(1);
    press(4'd2);
    press(4'd8);
    check("t6 mid entry", digit_count_o, 3'd2);
    #2 rst_i = 1'b1;
    #1;
    check("t6 async count", digit_count_o, 3'd0);
    check("t6 async bcd0", bcd_0_o, 4'd0);
    step(1);
    rst_i = 1'b0;
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
